// File: rtl/fsm_mode_dcounter.sv
// fsm_mode_dcounter: loadable down-counter with per-mode load values.
// A two-state machine tracks whether a loaded count is running down
// towards its terminal count.
//
// Ports:
//   clock_i   - main clock, rising edge
//   resetb_i  - asynchronous active-low reset
//   clr_i     - synchronous clear (count to all-ones, IDLE, flags cleared)
//   en_i      - global enable; low holds all state
//   load_i    - load request, value selected by mode_i
//   mode_i    - load mode index
//   dec_i     - decrement request
//   cpt_o     - current count (register)
//   zero_o    - combinational cpt_o == 0
//   done_o    - one-cycle terminal-count pulse (register)
//   busy_o    - high while in RUN
//   mode_o    - mode of the last accepted load
//   err_o     - sticky invalid-mode flag
module fsm_mode_dcounter #(
  parameter int unsigned WIDTH                 = 9,
  parameter int unsigned NB_MODES              = 5,
  parameter int unsigned LOAD_VALUES [NB_MODES] = '{8, 17, 16, 185, 184},
  parameter bit          WRAP                  = 1'b1,
  localparam int unsigned MW = (NB_MODES > 1) ? $clog2(NB_MODES) : 1
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [MW-1:0]    mode_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cpt_o,
  output logic             zero_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [MW-1:0]    mode_o,
  output logic             err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Every load value must fit the counter width.
  for (genvar g = 0; g < NB_MODES; g++) begin : g_load_chk
    if ((64'(LOAD_VALUES[g]) >> WIDTH) != 64'd0) begin : g_too_wide
      $error("fsm_mode_dcounter: LOAD_VALUES[%0d] does not fit in WIDTH bits", g);
    end
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cpt_q,   cpt_d;
  logic             done_q,  done_d;
  logic [MW-1:0]    mode_q,  mode_d;
  logic             err_q,   err_d;

  logic             mode_valid;
  logic [WIDTH-1:0] load_val;

  // Load value lookup; only meaningful when mode_valid is set.
  always_comb begin
    load_val   = '0;
    mode_valid = (32'(mode_i) < NB_MODES);
    for (int i = 0; i < NB_MODES; i++) begin
      if (32'(mode_i) == 32'(i)) begin
        load_val = WIDTH'(LOAD_VALUES[i]);
      end
    end
  end

  // State register.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      cpt_q   <= '1;
      done_q  <= 1'b0;
      mode_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cpt_q   <= cpt_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: clear > enable-hold > load > decrement > hold.
  always_comb begin
    state_d = state_q;
    cpt_d   = cpt_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    err_d   = err_q;

    if (clr_i) begin
      state_d = IDLE;
      cpt_d   = '1;
      mode_d  = '0;
      err_d   = 1'b0;
    end else if (!en_i) begin
      // hold everything; done_d already low
    end else if (load_i) begin
      // A load swallows any same-cycle decrement, including a terminal one.
      if (mode_valid) begin
        cpt_d   = load_val;
        mode_d  = mode_i;
        if (load_val != '0) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (dec_i) begin
      if (WRAP || (cpt_q != '0)) begin
        cpt_d = cpt_q - WIDTH'(1);
      end
      // Terminal count only in RUN; IDLE decrements free-run silently.
      if ((state_q == RUN) && (cpt_q == WIDTH'(1))) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  assign cpt_o  = cpt_q;
  assign zero_o = (cpt_q == '0);
  assign done_o = done_q;
  assign busy_o = (state_q == RUN);
  assign mode_o = mode_q;
  assign err_o  = err_q;

endmodule

// File: doc/fsm_mode_dcounter.md
FSM_MODE_DCOUNTER -- requirements
Module: fsm_mode_dcounter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, meaning counter width in bits.
REQ-002 The block SHALL have parameter NB_MODES, default 5, meaning number of load modes.
REQ-003 The block SHALL have parameter LOAD_VALUES, an array of NB_MODES WIDTH-bit values with default {8, 17, 16, 185, 184}, meaning the load value per mode, indexed by mode number.
REQ-004 The block SHALL have parameter WRAP, default 1, meaning 1 = wrap 0 to all-ones on decrement and 0 = saturate at 0.
REQ-005 The block SHALL have port clock_i, input, 1 bit: the single main clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port resetb_i, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port clr_i, input, 1 bit: synchronous clear.
REQ-008 The block SHALL have port en_i, input, 1 bit: global enable.
REQ-009 The block SHALL have port load_i, input, 1 bit: load request.
REQ-010 The block SHALL have port mode_i, input, MW = max(1, clog2(NB_MODES)) bits: mode selected on load.
REQ-011 The block SHALL have port dec_i, input, 1 bit: decrement request.
REQ-012 The block SHALL have port cpt_o, output, WIDTH bits: current count, driven directly from a register.
REQ-013 The block SHALL have port zero_o, output, 1 bit: combinational (cpt_o == 0).
REQ-014 The block SHALL have port done_o, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-015 The block SHALL have port busy_o, output, 1 bit: asserted while in state RUN.
REQ-016 The block SHALL have port mode_o, output, MW bits: mode captured on the last accepted load.
REQ-017 The block SHALL have port err_o, output, 1 bit: sticky invalid-mode flag.

Function
REQ-018 The block SHALL implement a two-state machine with states IDLE and RUN; busy_o = (state == RUN).
REQ-019 The block SHALL evaluate per-cycle actions in this priority order: clr_i, then en_i=0 (hold), then load_i, then dec_i, then hold.
REQ-020 clr_i=1 SHALL, independent of en_i, on the next edge set cpt to all-ones, state to IDLE, err_o to 0, done_o to 0 and mode_o to 0.
REQ-021 en_i=0 (with clr_i=0) SHALL hold cpt, state, mode_o and err_o, and SHALL drive done_o to 0.
REQ-022 A valid load (en_i=1, load_i=1, mode_i < NB_MODES) SHALL set cpt to LOAD_VALUES[mode_i] and mode_o to mode_i on the next edge.
REQ-023 After a valid load the state SHALL be RUN if the loaded value is nonzero; if the loaded value is 0 the state SHALL be IDLE and done_o SHALL be 1.
REQ-024 An invalid load (mode_i >= NB_MODES) SHALL set err_o to 1 and SHALL leave cpt, state and mode_o unchanged.
REQ-025 A load SHALL ignore dec_i in the same cycle, including when the load coincides with a 1-to-0 decrement, in which case no done_o pulse SHALL occur.
REQ-026 A decrement (en_i=1, load_i=0, dec_i=1) SHALL set cpt to cpt-1 modulo 2^WIDTH.
REQ-027 When WRAP=0 and cpt=0, a decrement SHALL hold cpt at 0.
REQ-028 When a decrement in RUN takes cpt from 1 to 0, done_o SHALL be 1 on the cycle cpt_o first reads 0, and the state SHALL move to IDLE on that same edge.
REQ-029 done_o SHALL be 0 in every cycle other than the cases in REQ-023 and REQ-028, so it is a single-cycle pulse.
REQ-030 In IDLE, decrements SHALL still apply (legacy free-run), but SHALL never assert done_o and SHALL never enter RUN.
REQ-031 All arithmetic SHALL be WIDTH-bit unsigned, with no carry out.
REQ-032 A LOAD_VALUES entry wider than WIDTH SHALL be a parameter error, flagged by an elaboration-time assertion.

Reset
REQ-033 resetb_i=0 SHALL immediately, without a clock edge, set cpt_o to all-ones (511 at default WIDTH), state to IDLE, done_o to 0, err_o to 0 and mode_o to 0; zero_o then reads 0.
REQ-034 Reset asserted mid-count SHALL abort the count with no done_o pulse.
REQ-035 Reset release SHALL take effect on the first rising edge of clock_i after resetb_i rises.

Verification
REQ-036 Scenario, reset: defaults, resetb_i pulsed low -> cpt_o=511, busy_o=0, done_o=0, zero_o=0, err_o=0, mode_o=0.
REQ-037 Scenario, load mode 0: load mode 0 then dec_i held 1 -> cpt_o reads 8,7,...,1,0 on successive cycles; done_o=1 only in the cpt_o=0 cycle; busy_o falls in that same cycle.
REQ-038 Scenario, enable hold: load mode 1 (17), count to 5, then en_i=0 for 3 cycles -> cpt_o stays 5 and done_o=0; after en_i returns to 1, cpt_o=4.
REQ-039 Scenario, invalid mode: load with mode_i=5 -> err_o=1 with cpt_o and mode_o unchanged; then clr_i=1 -> cpt_o=511 and err_o=0.
REQ-040 Scenario, boundary at 0: WRAP=1 with cpt_o=0 in IDLE and dec_i -> cpt_o=511 and done_o=0; WRAP=0 with the same stimulus -> cpt_o stays 0.
REQ-041 Scenario, load/decrement collision: load mode 3 in the cycle cpt goes 1 to 0 -> cpt_o=185, busy_o=1, no done_o; then resetb_i low mid-count at 100 -> cpt_o=511 with no clock edge needed.
